// File: rtl/multi_edge_det.sv
// multi_edge_det: per-channel button conditioner.
// Each channel runs its raw input through a synchroniser and then a debounce
// counter. The channel reports its debounced level, one-cycle rise and fall
// flags, and a sticky event bit. o_irq is the OR of all event bits.
module multi_edge_det #(
    parameter int CH   = 4,
    parameter int SYNC = 2,
    parameter int DEB  = 1000
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [CH-1:0] i_btn,
    input  logic [CH-1:0] i_pos_en,
    input  logic [CH-1:0] i_neg_en,
    input  logic [CH-1:0] i_evt_clr,
    output logic [CH-1:0] o_level,
    output logic [CH-1:0] posedge_flag,
    output logic [CH-1:0] negedge_flag,
    output logic [CH-1:0] o_evt,
    output logic          o_irq
);

    localparam int CNT_W = $clog2(DEB + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB - 1);

    if (CH < 1 || CH > 32) begin : g_bad_ch
        $error("multi_edge_det: CH must be in 1..32");
    end
    if (SYNC < 2 || SYNC > 4) begin : g_bad_sync
        $error("multi_edge_det: SYNC must be in 2..4");
    end
    if (DEB < 1 || DEB > (1 << 20)) begin : g_bad_deb
        $error("multi_edge_det: DEB must be in 1..2^20");
    end

    logic [CH-1:0]    sync_q [SYNC];
    logic [CH-1:0]    synced;
    logic [CNT_W-1:0] cnt_q  [CH];
    logic [CH-1:0]    accept;
    logic [CH-1:0]    rise;
    logic [CH-1:0]    fall;
    logic [CH-1:0]    evt_set;

    assign synced = sync_q[SYNC-1];

    // Synchroniser chain: stage 0 samples the asynchronous button levels.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int k = 0; k < SYNC; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= i_btn;
            for (int k = 1; k < SYNC; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // A channel accepts its new level once the mismatch has been seen DEB times in a row.
    always_comb begin
        accept = '0;
        for (int i = 0; i < CH; i++) begin
            accept[i] = (synced[i] != o_level[i]) && (cnt_q[i] == CNT_TC);
        end
    end

    assign rise    = accept & synced;
    assign fall    = accept & ~synced;
    assign evt_set = (rise & i_pos_en) | (fall & i_neg_en);

    // Debounce counters: any agreement with the current level restarts qualification.
    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < CH; i++) begin
            if (sys_rst) begin
                cnt_q[i] <= '0;
            end else if ((synced[i] == o_level[i]) || accept[i]) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Level, edge flags and sticky events; a new event beats a same-cycle clear.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            o_level      <= '0;
            posedge_flag <= '0;
            negedge_flag <= '0;
            o_evt        <= '0;
        end else begin
            o_level      <= o_level ^ accept;
            posedge_flag <= rise;
            negedge_flag <= fall;
            o_evt        <= evt_set | (o_evt & ~i_evt_clr);
        end
    end

    assign o_irq = |o_evt;

endmodule

// File: tb/tb_multi_edge_det.sv
// Bench for multi_edge_det (CH=4, SYNC=2, DEB=8): a directed table, two
// hand-built multi-cycle sequences, and a randomized run, all shadowed by a
// window-based reference model that is compared every cycle.
module tb_multi_edge_det;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 8;

    logic          sys_clk;
    logic          sys_rst;
    logic [CH-1:0] i_btn;
    logic [CH-1:0] i_pos_en;
    logic [CH-1:0] i_neg_en;
    logic [CH-1:0] i_evt_clr;
    logic [CH-1:0] o_level;
    logic [CH-1:0] posedge_flag;
    logic [CH-1:0] negedge_flag;
    logic [CH-1:0] o_evt;
    logic          o_irq;

    int tests  = 0;
    int failed = 0;

    multi_edge_det #(.CH(CH), .SYNC(SYNC), .DEB(DEB)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .i_btn        (i_btn),
        .i_pos_en     (i_pos_en),
        .i_neg_en     (i_neg_en),
        .i_evt_clr    (i_evt_clr),
        .o_level      (o_level),
        .posedge_flag (posedge_flag),
        .negedge_flag (negedge_flag),
        .o_evt        (o_evt),
        .o_irq        (o_irq)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: history of sampled button values per edge (0 while in
    // reset). The synced value used at edge e is the sample from edge e-SYNC.
    // A level change fires at edge n when the last DEB synced values (all on
    // non-reset edges) agree with each other and differ from the model level.
    logic [CH-1:0] hist_btn [$];
    logic          hist_rst [$];
    logic [CH-1:0] m_level = '0;
    logic [CH-1:0] m_pos   = '0;
    logic [CH-1:0] m_neg   = '0;
    logic [CH-1:0] m_evt   = '0;

    function automatic logic synced_at(int e, int ch);
        int idx;
        idx = e - SYNC;
        if (idx < 0) return 1'b0;
        return hist_btn[idx][ch];
    endfunction

    task automatic model_edge(input logic [CH-1:0] btn, input logic [CH-1:0] pe,
                              input logic [CH-1:0] ne, input logic [CH-1:0] clr,
                              input logic rst);
        int   n;
        logic fire;
        logic v;
        n = hist_btn.size();
        hist_btn.push_back(rst ? '0 : btn);
        hist_rst.push_back(rst);
        if (rst) begin
            m_level = '0; m_pos = '0; m_neg = '0; m_evt = '0;
            return;
        end
        for (int ch = 0; ch < CH; ch++) begin
            v    = synced_at(n, ch);
            fire = (v != m_level[ch]);
            for (int e = n - DEB + 1; e <= n; e++) begin
                if (e < 0) fire = 1'b0;
                else if (hist_rst[e] || synced_at(e, ch) != v) fire = 1'b0;
            end
            m_pos[ch] = fire & v;
            m_neg[ch] = fire & ~v;
            m_evt[ch] = (fire & (v ? pe[ch] : ne[ch])) | (m_evt[ch] & ~clr[ch]);
            if (fire) m_level[ch] = v;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic [CH-1:0] btn, input logic [CH-1:0] pe,
                        input logic [CH-1:0] ne, input logic [CH-1:0] clr,
                        input logic rst);
        i_btn = btn; i_pos_en = pe; i_neg_en = ne; i_evt_clr = clr; sys_rst = rst;
        @(posedge sys_clk);
        model_edge(btn, pe, ne, clr, rst);
        #1;
        check("model_level", o_level, m_level);
        check("model_pos", posedge_flag, m_pos);
        check("model_neg", negedge_flag, m_neg);
        check("model_evt", o_evt, m_evt);
        check("model_irq", o_irq, |m_evt);
        check("flag_excl", posedge_flag & negedge_flag, '0);
    endtask

    typedef struct {
        logic [CH-1:0] btn, pe, ne, clr;
        logic          rst;
        int            n;
        logic [CH-1:0] e_level, e_pos, e_neg, e_evt;
        logic          e_irq;
    } vec_t;

    vec_t vecs [$];

    function automatic void add_vec(logic [CH-1:0] btn, logic [CH-1:0] pe, logic [CH-1:0] ne,
                                    logic [CH-1:0] clr, logic rst, int n,
                                    logic [CH-1:0] e_level, logic [CH-1:0] e_pos,
                                    logic [CH-1:0] e_neg, logic [CH-1:0] e_evt, logic e_irq);
        vec_t v;
        v.btn = btn; v.pe = pe; v.ne = ne; v.clr = clr; v.rst = rst; v.n = n;
        v.e_level = e_level; v.e_pos = e_pos; v.e_neg = e_neg; v.e_evt = e_evt; v.e_irq = e_irq;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [CH-1:0] rb;
        logic [CH-1:0] bounce_btn;
        int            hold [CH];
        logic [5:0]    bpat;
        int            pos_cnt;

        i_btn = '0; i_pos_en = '0; i_neg_en = '0; i_evt_clr = '0; sys_rst = 1'b1;

        //       btn      pe       ne       clr      rst  n   level    pos      neg      evt      irq
        add_vec(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 9, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0, 7, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 12, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0, 9, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1, 4'b0101, 4'b0100, 4'b0000, 4'b0100, 1'b1);
        add_vec(4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0, 3, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 1'b1);
        add_vec(4'b0001, 4'b0100, 4'b0000, 4'b0000, 1'b0, 9, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 1'b1);
        add_vec(4'b0001, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 1'b1);
        add_vec(4'b0001, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b0001, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b1001, 4'b1000, 4'b0000, 4'b0000, 1'b0, 9, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b1001, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1, 4'b1001, 4'b1000, 4'b0000, 4'b1000, 1'b1);
        add_vec(4'b1001, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1, 4'b1001, 4'b0000, 4'b0000, 4'b1000, 1'b1);
        add_vec(4'b1001, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b1101, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1, 4'b1101, 4'b0100, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 7, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add_vec(4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1, 4'b1001, 4'b0000, 4'b0100, 4'b0000, 1'b0);

        for (int v = 0; v < vecs.size(); v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                tick(vecs[v].btn, vecs[v].pe, vecs[v].ne, vecs[v].clr, vecs[v].rst);
            end
            check($sformatf("vec%0d_level", v), o_level, vecs[v].e_level);
            check($sformatf("vec%0d_pos", v), posedge_flag, vecs[v].e_pos);
            check($sformatf("vec%0d_neg", v), negedge_flag, vecs[v].e_neg);
            check($sformatf("vec%0d_evt", v), o_evt, vecs[v].e_evt);
            check($sformatf("vec%0d_irq", v), o_irq, vecs[v].e_irq);
        end

        // Bounce on channel 1: 1,0,1,1,0 then steady 1; one rise expected at step 14.
        bpat    = 6'b101101;
        pos_cnt = 0;
        for (int k = 0; k < 22; k++) begin
            bounce_btn    = 4'b1001;
            bounce_btn[1] = (k < 5) ? bpat[k] : 1'b1;
            tick(bounce_btn, '0, '0, '0, 1'b0);
            check($sformatf("bounce_pos_k%0d", k), posedge_flag[1], (k == 14) ? 1'b1 : 1'b0);
            check($sformatf("bounce_neg_k%0d", k), negedge_flag[1], 1'b0);
            if (posedge_flag[1]) pos_cnt++;
        end
        check("bounce_pos_count", pos_cnt, 1);
        check("bounce_level", o_level, 4'b1011);

        // Reset while every counter sits at 5 with inputs held high.
        for (int k = 0; k < 12; k++) tick(4'b0000, '0, '0, '0, 1'b0);
        check("pre_rst_level", o_level, 4'b0000);
        for (int k = 0; k < 7; k++) tick(4'b1111, 4'b1111, '0, '0, 1'b0);
        check("pre_rst_level_held", o_level, 4'b0000);
        tick(4'b1111, 4'b1111, '0, '0, 1'b1);
        check("rst_level", o_level, 4'b0000);
        check("rst_pos", posedge_flag, 4'b0000);
        check("rst_evt", o_evt, 4'b0000);
        check("rst_irq", o_irq, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick(4'b1111, 4'b1111, '0, '0, 1'b0);
            check($sformatf("rst_rise_k%0d", k), posedge_flag, (k == 9) ? 4'b1111 : 4'b0000);
            check($sformatf("rst_lvl_k%0d", k), o_level, (k >= 9) ? 4'b1111 : 4'b0000);
        end
        check("rst_rise_irq", o_irq, 1'b1);

        // Randomized phase: per-channel random hold lengths straddling DEB.
        rb = o_level;
        for (int i = 0; i < CH; i++) hold[i] = $urandom_range(1, 14);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CH; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    rb[i]   = ~rb[i];
                    hold[i] = $urandom_range(1, 14);
                end
            end
            tick(rb, CH'($urandom), CH'($urandom),
                 ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0,
                 ($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/multi_edge_det.md
MULTI_EDGE_DET -- requirements
Module: multi_edge_det

Interface
REQ-001 SHALL provide parameter CH, default 4, meaning the number of independent button channels (range 1..32).
REQ-002 SHALL provide parameter SYNC, default 2, meaning the synchroniser stages per channel (range 2..4).
REQ-003 SHALL provide parameter DEB, default 1000, meaning the consecutive cycles a new level must hold before it is accepted (range 1..2^20).
REQ-004 SHALL derive localparam CNT_W = clog2(DEB+1), the per-channel debounce counter width.
REQ-005 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-006 sys_rst  input  1  reset, synchronous, active-high.
REQ-007 i_btn  input  CH  asynchronous raw button levels, bit i = channel i.
REQ-008 i_pos_en  input  CH  per-channel enable for latching rising events.
REQ-009 i_neg_en  input  CH  per-channel enable for latching falling events.
REQ-010 i_evt_clr  input  CH  per-channel clear of the sticky event bit, level-sampled.
REQ-011 o_level  output  CH  debounced stable level.
REQ-012 posedge_flag  output  CH  one-cycle pulse on a debounced 0->1 transition.
REQ-013 negedge_flag  output  CH  one-cycle pulse on a debounced 1->0 transition.
REQ-014 o_evt  output  CH  sticky event bits.
REQ-015 o_irq  output  1  OR of all o_evt bits.

Function
REQ-016 Each channel SHALL pass i_btn through a SYNC-deep flop chain; the last stage is the synced value s[i].
REQ-017 When s[i] == o_level[i], the channel counter SHALL load 0.
REQ-018 When s[i] != o_level[i] and counter < DEB-1, the counter SHALL increment by 1.
REQ-019 When s[i] != o_level[i] and counter == DEB-1, o_level[i] SHALL load s[i] and the counter SHALL load 0.
REQ-020 Latency: if i_btn[i] is stable from sampling edge E0, o_level[i] SHALL change at edge E0+SYNC+DEB-1 (E0+SYNC when DEB=1).
REQ-021 A pulse or bounce whose synced width is < DEB cycles SHALL NOT change o_level, and SHALL NOT assert any flag or event.
REQ-022 posedge_flag[i] SHALL be a registered output, high for exactly one cycle: the cycle in which o_level[i] first reads 1.
REQ-023 negedge_flag[i] SHALL be a registered output, high for exactly one cycle: the cycle in which o_level[i] first reads 0.
REQ-024 posedge_flag[i] and negedge_flag[i] SHALL never be high together.
REQ-025 On an edge where a flag is produced, o_evt[i] SHALL set if (rise & i_pos_en[i]) | (fall & i_neg_en[i]).
REQ-026 o_evt[i] SHALL clear at an edge where i_evt_clr[i]=1 and no enabled event is produced on that same edge.
REQ-027 If set and clear coincide on an edge, set SHALL win so that no event is lost.
REQ-028 Channels SHALL be fully independent; activity on one channel SHALL NOT affect any other channel.
REQ-029 o_irq SHALL be combinational OR of o_evt, with no added latency.
REQ-030 Out-of-range parameters SHALL fail elaboration.

Reset
REQ-031 While sys_rst=1 at an edge, all sync stages, counters, o_level, both flag vectors and o_evt SHALL load 0; o_irq consequently reads 0.
REQ-032 Reset asserted mid-debounce SHALL discard partial counts; after release, qualification SHALL restart from zero.
REQ-033 After reset release, a channel whose i_btn is held at 1 SHALL produce a rising flag after SYNC+DEB-1 edges; this is intended power-up behaviour.

Verification
REQ-034 CH=4, SYNC=2, DEB=8: i_btn[0] 0->1 stable from edge E0 -> o_level[0]=1 and posedge_flag[0] pulses exactly one cycle at edge E0+9; channels 1-3 stay 0.
REQ-035 DEB=8: i_btn[1] glitch high for 7 cycles, then 0 -> o_level[1], flags and o_evt[1] remain 0 throughout.
REQ-036 DEB=8: bounce 1,0,1,1,0 then stable 1 -> a single posedge_flag, 8 cycles after the last synced 0->1 transition; no negedge_flag.
REQ-037 i_pos_en[2]=1, i_neg_en[2]=0, press then release -> o_evt[2] and o_irq set on the rise only; i_evt_clr[2] pulse clears both; the release sets nothing.
REQ-038 i_evt_clr[3]=1 on the same edge as an enabled rising event -> o_evt[3]=1 afterwards.
REQ-039 sys_rst pulsed at counter=5 with input held high -> all outputs 0; rising flag arrives SYNC+DEB-1 edges after release.
